// File: rtl/audio_serial_pkg.sv
// Shared constants, sample-pair type and serializer bit helper for the audio serial master.
package audio_serial_pkg;
    localparam int SAMPLE_W           = 24;
    localparam int HALF_BITS          = 32;
    localparam int DATA_BITS_PER_HALF = 24;
    localparam int BIT_CNT_W          = $clog2(HALF_BITS);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT      = BIT_CNT_W'(HALF_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_BITS_PER_HALF - 1);

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } sample_pair_t;

    // Left-justified: bit k of a half-frame carries sample[23-k]; pad slots are zero.
    function automatic logic tx_bit(input logic [SAMPLE_W-1:0] s, input logic [BIT_CNT_W-1:0] k);
        logic [BIT_CNT_W-1:0] idx;
        idx = (k <= LAST_DATA_BIT) ? LAST_DATA_BIT - k : '0;
        return (k <= LAST_DATA_BIT) ? s[idx] : 1'b0;
    endfunction
endpackage

// File: rtl/audio_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV clk cycles and flags the cycle before each edge.
module audio_bclk_gen #(
    parameter int BCLK_DIV = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic bclk_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    generate
        if (BCLK_DIV < 2) begin : g_bad_div
            $error("audio_bclk_gen: BCLK_DIV must be at least 2");
        end
    endgenerate

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             term;

    assign term = (div_q == DIV_LAST);

    always_comb begin
        div_d  = div_q + DIV_W'(1);
        bclk_d = bclk_q;
        if (term) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;
    assign rise_o = term & ~bclk_q;
    assign fall_o = term & bclk_q;
endmodule

// File: rtl/audio_serial_master.sv
// Codec-side audio serial link master: BCLK/LRCK generation, left-justified 24-in-32 TX and RX.
// Optional underrun counter output enabled by AUDIO_SERIAL_MASTER_UNDERRUN_CNT_EN.
module audio_serial_master
    import audio_serial_pkg::*;
#(
    parameter int BCLK_DIV = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                aud_bclk,
    output logic                aud_lrck,
    output logic                aud_sdata,
    input  logic                sdin,
    output logic                out_valid,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic                underrun
`ifdef AUDIO_SERIAL_MASTER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         underrun_cnt
`endif
);
    logic rise, fall;

    audio_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .bclk_o  (aud_bclk),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    logic                 lrck_q, lrck_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 sdata_q, sdata_d;
    sample_pair_t         tx_q, tx_d;
    logic [SAMPLE_W-1:0]  sr_l_q, sr_l_d, sr_r_q, sr_r_d;
    logic [SAMPLE_W-1:0]  out_l_q, out_l_d, out_r_q, out_r_d;
    logic                 out_valid_q, out_valid_d;
    logic                 underrun_q, underrun_d;
    logic                 have_left_q, have_left_d;
    logic                 frame_start, accept, done;

    // The falling tick that wraps the right half starts a new frame.
    assign frame_start = fall & ~lrck_q & (bit_cnt_q == LAST_BIT);
    assign accept      = frame_start & in_valid;
    assign done        = rise & ~lrck_q & (bit_cnt_q == LAST_DATA_BIT);

    always_comb begin
        lrck_d      = lrck_q;
        bit_cnt_d   = bit_cnt_q;
        sdata_d     = sdata_q;
        tx_d        = tx_q;
        sr_l_d      = sr_l_q;
        sr_r_d      = sr_r_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        have_left_d = have_left_q;
        out_valid_d = 1'b0;
        underrun_d  = frame_start & ~in_valid;

        if (frame_start) begin
            tx_d = accept ? sample_pair_t'({in_left, in_right}) : '0;
        end

        // MSB must leave on the same edge that loads tx, so serialize from tx_d.
        if (fall) begin
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                lrck_d    = ~lrck_q;
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
            sdata_d = tx_bit(lrck_d ? tx_d.left : tx_d.right, bit_cnt_d);
        end

        if (rise && bit_cnt_q <= LAST_DATA_BIT) begin
            if (lrck_q) sr_l_d = {sr_l_q[SAMPLE_W-2:0], sdin};
            else        sr_r_d = {sr_r_q[SAMPLE_W-2:0], sdin};
        end

        if (rise && lrck_q && bit_cnt_q == LAST_DATA_BIT) begin
            have_left_d = 1'b1;
        end

        if (done && have_left_q) begin
            out_l_d     = sr_l_q;
            out_r_d     = sr_r_d;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lrck_q      <= 1'b0;
            bit_cnt_q   <= LAST_BIT;
            sdata_q     <= 1'b0;
            tx_q        <= '0;
            sr_l_q      <= '0;
            sr_r_q      <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            have_left_q <= 1'b0;
        end else begin
            lrck_q      <= lrck_d;
            bit_cnt_q   <= bit_cnt_d;
            sdata_q     <= sdata_d;
            tx_q        <= tx_d;
            sr_l_q      <= sr_l_d;
            sr_r_q      <= sr_r_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            underrun_q  <= underrun_d;
            have_left_q <= have_left_d;
        end
    end

`ifdef AUDIO_SERIAL_MASTER_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun_d && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ucnt_q <= '0;
        else          ucnt_q <= ucnt_d;
    end

    assign underrun_cnt = ucnt_q;
`endif

    assign in_ready  = frame_start;
    assign aud_lrck  = lrck_q;
    assign aud_sdata = sdata_q;
    assign out_valid = out_valid_q;
    assign out_left  = out_l_q;
    assign out_right = out_r_q;
    assign underrun  = underrun_q;
endmodule

// File: tb/tb_audio_serial_master.sv
// Randomized scoreboard bench for audio_serial_master in loopback (aud_sdata -> sdin).
module tb_audio_serial_master;
    localparam int BD    = 2;
    localparam int HB    = 2 * BD;       // clk cycles per bit
    localparam int FRAME = 64 * HB;      // clk cycles per frame
    localparam int OV_OFS = 55 * HB + BD; // out_valid offset within a frame

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_left = '0, in_right = '0;
    logic        aud_bclk, aud_lrck, aud_sdata, sdin;
    logic        out_valid, underrun;
    logic [23:0] out_left, out_right;
`ifdef AUDIO_SERIAL_MASTER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    assign sdin = aud_sdata;

    audio_serial_master #(.BCLK_DIV(BD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_left   (in_left),
        .in_right  (in_right),
        .aud_bclk  (aud_bclk),
        .aud_lrck  (aud_lrck),
        .aud_sdata (aud_sdata),
        .sdin      (sdin),
        .out_valid (out_valid),
        .out_left  (out_left),
        .out_right (out_right),
        .underrun  (underrun)
`ifdef AUDIO_SERIAL_MASTER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Time reference: clk edges since reset release.
    int cyc_rel = 0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc_rel <= 0;
        else          cyc_rel <= cyc_rel + 1;
    end

    // Reference model: frame timing from cycle arithmetic, data from the pair decided at in_ready.
    logic [47:0] sb[$];
    logic [47:0] pending = '0, cur = '0, got;
    logic        pend_under = 1'b0;
    int          model_cnt = 0;

    always @(negedge clk) begin
        int c, n, k;
        logic fs, e_sd, e_ov, e_under, e_ready;
        logic [23:0] s;
        if (!reset_n) begin
            check("reset_outputs",
                  {in_ready, aud_bclk, aud_lrck, aud_sdata, out_valid, underrun, out_left, out_right},
                  '0);
            sb.delete();
            pending = '0; cur = '0; pend_under = 1'b0; model_cnt = 0;
        end else begin
            c = cyc_rel;
            e_ready = (c >= HB - 1) && ((c - (HB - 1)) % FRAME == 0);
            check("in_ready", in_ready, e_ready);
            if (in_ready) begin
                pending    = in_valid ? {in_left, in_right} : 48'd0;
                pend_under = ~in_valid;
                sb.push_back(pending);
            end
            fs = (c >= HB) && ((c - HB) % FRAME == 0);
            if (fs) cur = pending;
            check("bclk", aud_bclk, (c / BD) % 2);
            check("lrck", aud_lrck, (c >= HB) && (((c - HB) / (FRAME / 2)) % 2 == 0));
            e_sd = 1'b0;
            if (c >= HB) begin
                n = ((c - HB) / HB) % 64;
                k = n % 32;
                s = (n < 32) ? cur[47:24] : cur[23:0];
                if (k < 24) e_sd = s[23-k];
            end
            check("sdata", aud_sdata, e_sd);
            e_under = fs && pend_under;
            if (e_under) model_cnt++;
            check("underrun", underrun, e_under);
`ifdef AUDIO_SERIAL_MASTER_UNDERRUN_CNT_EN
            check("underrun_cnt", underrun_cnt, (model_cnt > 65535) ? 65535 : model_cnt);
`endif
            e_ov = (c >= HB) && ((c - HB) % FRAME == OV_OFS);
            check("out_valid", out_valid, e_ov);
            if (out_valid) begin
                if (sb.size() == 0) check("sb_nonempty", out_valid, 1'b0);
                else begin
                    got = sb.pop_front();
                    check("out_pair", {out_left, out_right}, got);
                end
            end
        end
    end

    task automatic next_frame(input logic [23:0] l, input logic [23:0] r, input logic v);
        int t;
        in_left = l; in_right = r; in_valid = v;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 2 * FRAME + 10);
        if (!in_ready) check("in_ready_wait", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        #1 reset_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;

        next_frame(24'hA5A5A5, 24'h123456, 1'b1);
        next_frame(24'h000001, 24'h800000, 1'b1);
        next_frame(24'h7FFFFF, 24'hFFFFFF, 1'b1);
        next_frame(24'h111111, 24'h222222, 1'b1);
        repeat (3) next_frame(24'h5A5A5A, 24'h3C3C3C, 1'b0);
        next_frame(24'hC0FFEE, 24'h0BEEF0, 1'b1);

        // Inputs churn every cycle while valid stays high.
        in_valid = 1'b1;
        repeat (3 * FRAME) begin
            in_left  = 24'($urandom);
            in_right = 24'($urandom);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 6; i++)
            next_frame(24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)));

        // Reset in the middle of a left half.
        t = 0;
        while (!aud_lrck && t < 2 * FRAME) begin
            @(negedge clk);
            t++;
        end
        check("lrck_seen", aud_lrck, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;

        next_frame(24'hABCDEF, 24'h654321, 1'b1);
        next_frame(24'($urandom), 24'($urandom), 1'b1);
        repeat (FRAME + 10) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
